// File: rtl/addr_tree_pipe.sv
// Pipelined signed adder tree: one register level per binary tree level, valid travels alongside.
// Define ADDR_TREE_PIPE_CE_EN to add a clock-enable input ce that freezes the whole pipeline.
module addr_tree_pipe #(
  parameter  int IN_WIDTH   = 32,
  parameter  int NUM_INPUTS = 9,
  localparam int LEVELS     = (NUM_INPUTS <= 1) ? 1 : $clog2(NUM_INPUTS),
  localparam int OUT_WIDTH  = IN_WIDTH + LEVELS
) (
  input  logic                               clk,
  input  logic                               rst,
`ifdef ADDR_TREE_PIPE_CE_EN
  input  logic                               ce,
`endif
  input  logic                               valid_i,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]     d_i,
  output logic                               valid_o,
  output logic signed [OUT_WIDTH-1:0]        d_o
);

  function automatic int level_cnt(input int j);
    return (NUM_INPUTS + (1 << j) - 1) >> j;
  endfunction

  // Bit offset of level j inside lvl_flat; level j elements are IN_WIDTH+j bits each.
  function automatic int lvl_off(input int j);
    int off;
    off = 0;
    for (int i = 0; i < j; i++) off += level_cnt(i) * (IN_WIDTH + i);
    return off;
  endfunction

  localparam int TOTAL_BITS = lvl_off(LEVELS + 1);

  logic                  adv;
  logic [TOTAL_BITS-1:0] lvl_flat;
  logic [LEVELS-1:0]     vld_q;
  logic [LEVELS-1:0]     vld_d;

`ifdef ADDR_TREE_PIPE_CE_EN
  assign adv = ce;
`else
  assign adv = 1'b1;
`endif

  assign lvl_flat[0 +: NUM_INPUTS*IN_WIDTH] = d_i;

  for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
    localparam int W  = IN_WIDTH + j;
    localparam int NP = level_cnt(j - 1);
    localparam int N  = level_cnt(j);
    localparam int PO = lvl_off(j - 1);
    localparam int CO = lvl_off(j);

    for (genvar k = 0; k < N; k++) begin : g_node
      logic signed [W-1:0] sum_d;
      logic signed [W-1:0] sum_q;

      if (2*k + 1 < NP) begin : g_add
        logic signed [W-2:0] a;
        logic signed [W-2:0] b;
        assign a     = lvl_flat[PO + (2*k)*(W-1)   +: W-1];
        assign b     = lvl_flat[PO + (2*k+1)*(W-1) +: W-1];
        assign sum_d = {a[W-2], a} + {b[W-2], b};
      end else begin : g_pass
        // Odd leftover of the previous level: widen and carry forward.
        logic signed [W-2:0] a;
        assign a     = lvl_flat[PO + (2*k)*(W-1) +: W-1];
        assign sum_d = {a[W-2], a};
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q <= '0;
        end else if (adv) begin
          sum_q <= sum_d;
        end
      end

      assign lvl_flat[CO + k*W +: W] = sum_q;
    end
  end

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = valid_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else if (adv) begin
      vld_q <= vld_d;
    end
  end

  assign valid_o = vld_q[LEVELS-1];
  assign d_o     = lvl_flat[lvl_off(LEVELS) +: OUT_WIDTH];

endmodule

// File: tb/tb_addr_tree_pipe.sv
// Self-checking bench for addr_tree_pipe: four configurations against a delay-line sum model.
module tb_addr_tree_pipe;

  typedef struct {
    bit     v;
    longint s;
  } ent_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                valid_i = 1'b0;
  logic [287:0]        bus = '0;
`ifdef ADDR_TREE_PIPE_CE_EN
  logic                ce = 1'b1;
`endif
  logic                va, vb, vc, vd;
  logic signed [11:0]  da;
  logic signed [8:0]   db;
  logic signed [9:0]   dc;
  logic signed [35:0]  dd;

  int checks = 0;
  int errors = 0;

  // Per instance: latency, operand count, operand width.
  int lv [4] = '{4, 1, 2, 4};
  int nn [4] = '{9, 1, 3, 9};
  int ww [4] = '{8, 8, 8, 32};
  ent_t mq [4][$];

  always #5 clk = ~clk;

  addr_tree_pipe #(.IN_WIDTH(8), .NUM_INPUTS(9)) u_a (
    .clk(clk), .rst(rst),
`ifdef ADDR_TREE_PIPE_CE_EN
    .ce(ce),
`endif
    .valid_i(valid_i), .d_i(bus[71:0]), .valid_o(va), .d_o(da));

  addr_tree_pipe #(.IN_WIDTH(8), .NUM_INPUTS(1)) u_b (
    .clk(clk), .rst(rst),
`ifdef ADDR_TREE_PIPE_CE_EN
    .ce(ce),
`endif
    .valid_i(valid_i), .d_i(bus[7:0]), .valid_o(vb), .d_o(db));

  addr_tree_pipe #(.IN_WIDTH(8), .NUM_INPUTS(3)) u_c (
    .clk(clk), .rst(rst),
`ifdef ADDR_TREE_PIPE_CE_EN
    .ce(ce),
`endif
    .valid_i(valid_i), .d_i(bus[23:0]), .valid_o(vc), .d_o(dc));

  addr_tree_pipe u_d (
    .clk(clk), .rst(rst),
`ifdef ADDR_TREE_PIPE_CE_EN
    .ce(ce),
`endif
    .valid_i(valid_i), .d_i(bus), .valid_o(vd), .d_o(dd));

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sum_ops(input logic [287:0] b, input int n, input int w);
    longint       acc;
    longint       v;
    logic [287:0] t;
    acc = 0;
    for (int k = 0; k < n; k++) begin
      t   = b >> (k * w);
      v   = longint'(t[63:0]);
      v   = (v <<< (64 - w)) >>> (64 - w);
      acc = acc + v;
    end
    return acc;
  endfunction

  function automatic logic out_v(input int i);
    case (i)
      0:       return va;
      1:       return vb;
      2:       return vc;
      default: return vd;
    endcase
  endfunction

  function automatic logic signed [63:0] out_d(input int i);
    logic signed [63:0] r;
    case (i)
      0:       r = da;
      1:       r = db;
      2:       r = dc;
      default: r = dd;
    endcase
    return r;
  endfunction

  task automatic rand_bus();
    for (int w = 0; w < 9; w++) bus[w*32 +: 32] = $urandom;
  endtask

  task automatic set_all(input int val);
    for (int k = 0; k < 9; k++) bus[k*8 +: 8] = val[7:0];
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_v%0d", tag, i), out_v(i), 0);
      check($sformatf("%s_d%0d", tag, i), out_d(i), 0);
    end
  endtask

  // One clock: advance the model with what was presented at the edge, then compare all instances.
  task automatic step();
    bit adv_m;
    @(posedge clk);
    #1;
    adv_m = !rst;
`ifdef ADDR_TREE_PIPE_CE_EN
    if (!ce) adv_m = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mq[i].delete();
      end else if (adv_m) begin
        mq[i].push_back('{valid_i, sum_ops(bus, nn[i], ww[i])});
        if (mq[i].size() > lv[i]) void'(mq[i].pop_front());
      end
      if (rst) begin
        check($sformatf("rst_v%0d", i), out_v(i), 0);
        check($sformatf("rst_d%0d", i), out_d(i), 0);
      end else if (mq[i].size() == lv[i]) begin
        check($sformatf("v%0d", i), out_v(i), mq[i][0].v);
        check($sformatf("d%0d", i), out_d(i), mq[i][0].s);
      end else begin
        check($sformatf("fill_v%0d", i), out_v(i), 0);
      end
    end
  endtask

  initial begin
    int                 mix [9] = '{100, -100, 50, -50, 1, 2, 3, -4, 7};
    logic signed [63:0] got [$];
    int                 first_t;
    int                 last_t;

    step();
    step();
    check_zero("por");
    #3 rst = 1'b0;

    // Max positive, also covers the 1- and 3-input instances
    rand_bus(); set_all(127); valid_i = 1'b1;
    step();
    check("n1_pos", db, 127);
    valid_i = 1'b0; rand_bus();
    step();
    check("n3_pos", dc, 381);
    step(); step();
    check("maxpos_v", va, 1);
    check("maxpos", da, 1143);
    step();
    check("maxpos_v_after", va, 0);

    // Max negative exercises sign extension through the odd passthrough
    rand_bus(); set_all(-128); valid_i = 1'b1;
    step();
    check("n1_neg", db, -128);
    valid_i = 1'b0; rand_bus();
    step();
    check("n3_neg", dc, -384);
    step(); step();
    check("maxneg", da, -1152);

    // Back-to-back sets
    first_t = -1; last_t = -1;
    for (int t = 0; t < 10; t++) begin
      if (t < 5) begin
        set_all(t + 1); valid_i = 1'b1;
      end else begin
        rand_bus(); valid_i = 1'b0;
      end
      step();
      if (va) begin
        got.push_back(da);
        if (first_t < 0) first_t = t;
        last_t = t;
      end
    end
    check("pipe_cnt", got.size(), 5);
    check("pipe_run", last_t - first_t, 4);
    check("pipe_lat", first_t, 3);
    for (int i = 0; i < got.size(); i++) check($sformatf("pipe_%0d", i), got[i], 9 * (i + 1));

    // Mixed operands
    for (int k = 0; k < 9; k++) bus[k*8 +: 8] = mix[k][7:0];
    valid_i = 1'b1;
    step();
    check("n1_mix", db, 100);
    valid_i = 1'b0; rand_bus();
    step(); step(); step();
    check("mix", da, 9);

    // Async reset while a set is in flight
    for (int k = 0; k < 9; k++) bus[k*8 +: 8] = mix[k][7:0];
    valid_i = 1'b1;
    step();
    valid_i = 1'b0; rand_bus();
    step();
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    step();
    #3 rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      rand_bus();
      step();
      check("no_ghost", va, 0);
    end

    // Single operand, negative
    rand_bus(); bus[7:0] = 8'hFB; valid_i = 1'b1;
    step();
    check("n1_m5_v", vb, 1);
    check("n1_m5", db, -5);
    valid_i = 1'b0;

`ifdef ADDR_TREE_PIPE_CE_EN
    begin
      longint             exp_s;
      logic signed [63:0] held;
      rand_bus(); valid_i = 1'b1;
      exp_s = sum_ops(bus, 9, 8);
      step();
      valid_i = 1'b0; rand_bus();
      step();
      ce = 1'b0;
      held = da;
      for (int t = 0; t < 3; t++) begin
        rand_bus(); valid_i = 1'b1;
        step();
        check("ce_hold_d", da, held);
        check("ce_hold_v", va, 0);
      end
      ce = 1'b1; valid_i = 1'b0;
      step();
      check("ce_early", va, 0);
      step();
      check("ce_v", va, 1);
      check("ce_sum", da, exp_s);
    end
`endif

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      rand_bus();
      valid_i = 1'($urandom_range(0, 1));
`ifdef ADDR_TREE_PIPE_CE_EN
      ce = ($urandom_range(0, 7) != 0);
`endif
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_tree_pipe.md
Name: addr_tree_pipe

Overview:
- Parametrised, pipelined signed adder tree. Reduces NUM_INPUTS two's-complement operands to one full-precision sum.
- Generalises the fixed 3-input single-register adder. Operand count and width are configurable, there is one register level per binary tree level, and a valid flag travels alongside the data.
- Used after multiplier arrays in conv/fc layers to sum partial products before the accumulator.

Parameters:
- IN_WIDTH, 32, width of each signed operand.
- NUM_INPUTS, 9, number of operands, at least 1.
- LEVELS, derived as max(1, ceil(log2(NUM_INPUTS))). Number of tree levels and pipeline latency. Localparam, not to be overridden.
- OUT_WIDTH, derived as IN_WIDTH+LEVELS. Result width, guaranteed overflow-free. Localparam.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  d_i carries a valid operand set this cycle.
- d_i  input  NUM_INPUTS*IN_WIDTH  packed operands. Operand k is at bits [k*IN_WIDTH +: IN_WIDTH].
- valid_o  output  1  d_o holds a valid sum.
- d_o  output  OUT_WIDTH  signed sum, registered.

Behaviour:
- Reset: asserting rst clears all level registers, the valid pipeline, d_o and valid_o to 0 immediately, without waiting for clk. Release is synchronous to clk. Nothing in flight before reset may appear at the output afterwards.
- Level structure:
  - Level j (j=1..LEVELS) holds ceil(NUM_INPUTS/2^j) registers, each IN_WIDTH+j bits wide.
  - Each level register is the sum of a pair from level j-1. Both operands are sign-extended by 1 bit before adding.
  - When level j-1 has an odd count, its last element is sign-extended by 1 bit and registered unchanged (passthrough).
  - Level 0 is d_i, not registered.
- NUM_INPUTS=1: a single sign-extended register stage, so latency is 1 and OUT_WIDTH=IN_WIDTH+1.
- d_o is the single register of level LEVELS. No extra output register.
- Latency: exactly LEVELS cycles from sampling valid_i/d_i to valid_o/d_o.
- Throughput: one operand set per cycle, no bubbles, no backpressure (base build).
- Valid tracking: a LEVELS-deep shift register carries valid_i in step with the data.
- Data registers load every cycle regardless of valid_i. d_o is don't-care when valid_o=0, but must be deterministic, i.e. equal to the sum of whatever was on d_i.
- Arithmetic: pure two's-complement with no saturation or rounding. The result always equals the exact mathematical sum, since OUT_WIDTH covers the worst case.
- Back-to-back valid sets produce back-to-back valid outputs in the same order.
- Reset mid-operation: every in-flight set is discarded. valid_o stays 0 for LEVELS cycles after the first sample with valid_i=1 following reset release.

Optional Feature:
- Macro ADDR_TREE_PIPE_CE_EN.
- When defined:
  - Adds input port ce (1 bit), placed after rst.
  - ce=0 freezes every level register and the valid shift register; d_o/valid_o hold their values.
  - ce=1 advances the pipeline as normal.
  - valid_i/d_i are sampled only when ce=1.
  - Latency counts ce=1 cycles only.
  - Reset overrides ce.
- When undefined: no ce port, and the pipeline advances every cycle.

Test Plan:
- Max positive: IN_WIDTH=8, NUM_INPUTS=9 (LEVELS=4, OUT_WIDTH=12). All operands 127, valid_i=1 for 1 cycle → exactly 4 cycles later valid_o=1 for 1 cycle and d_o=1143 (12'h477).
- Max negative: same config, all operands -128 → d_o=-1152 (12'hB80), confirming sign extension through the odd passthrough path.
- Pipelining: same config, back-to-back sets {k,k,...,k} for k=1..5 with valid_i held high → valid_o high for 5 consecutive cycles, d_o = 9,18,27,36,45 in order.
- Mixed values and reset: operands 100,-100,50,-50,1,2,3,-4,7 → d_o=9. Assert rst asynchronously mid-flight 2 cycles after issue → valid_o and d_o drop to 0 before the next edge, and the set never emerges.
- Degenerate configs: NUM_INPUTS=1, IN_WIDTH=8, operand -5 → d_o=-5 (9 bits) after 1 cycle. NUM_INPUTS=3 (the 3-input case), operands 127,127,127 → d_o=381 after 2 cycles.
- With ADDR_TREE_PIPE_CE_EN: issue a set, hold ce=0 for 3 cycles mid-flight → d_o/valid_o frozen, and the result appears after 4 ce=1 cycles with the correct sum.
